// File: rtl/countdown_mod60.sv
// Two-digit countdown timer (units mod UNITS_MOD, tens mod TENS_MOD) with load, start/pause and borrow-out.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN (reload last loaded value on reaching 00 and keep running).
module countdown_mod60 #(
  parameter int UNITS_MOD = 10,
  parameter int TENS_MOD  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  input  logic       start,
  input  logic       pause,
  input  logic       tick,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       running,
  output logic       done,
  output logic       borrow_out
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  localparam logic [3:0] UNITS_MAX = 4'(UNITS_MOD - 1);
  localparam logic [3:0] TENS_MAX  = 4'(TENS_MOD - 1);

  state_t     r_state;
  logic [3:0] r_tens;
  logic [3:0] r_units;
  logic       r_borrow;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [3:0] r_reloadTens;
  logic [3:0] r_reloadUnits;
  logic       r_donePulse;
`endif

  logic [3:0] w_ldTens;
  logic [3:0] w_ldUnits;
  logic [3:0] w_decTens;
  logic [3:0] w_decUnits;
  logic       w_wrap;
  logic       w_decZero;
  logic       w_countZero;

  assign w_ldTens    = (load_tens  > TENS_MAX)  ? TENS_MAX  : load_tens;
  assign w_ldUnits   = (load_units > UNITS_MAX) ? UNITS_MAX : load_units;
  assign w_countZero = (r_tens == 4'd0) && (r_units == 4'd0);

  // Next value after one decrement; units wrap borrows from tens.
  always_comb begin
    w_decTens  = r_tens;
    w_decUnits = r_units;
    w_wrap     = 1'b0;
    if (r_units != 4'd0) begin
      w_decUnits = r_units - 4'd1;
    end else if (r_tens != 4'd0) begin
      w_decUnits = UNITS_MAX;
      w_decTens  = r_tens - 4'd1;
      w_wrap     = 1'b1;
    end
  end

  assign w_decZero = (w_decTens == 4'd0) && (w_decUnits == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_tens   <= 4'd0;
      r_units  <= 4'd0;
      r_borrow <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      r_reloadTens  <= 4'd0;
      r_reloadUnits <= 4'd0;
      r_donePulse   <= 1'b0;
`endif
    end else begin
      r_borrow <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      r_donePulse <= 1'b0;
`endif
      if (load && (r_state != RUN)) begin
        r_tens  <= w_ldTens;
        r_units <= w_ldUnits;
        r_state <= IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        r_reloadTens  <= w_ldTens;
        r_reloadUnits <= w_ldUnits;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            if (start) r_state <= w_countZero ? DONE : RUN;
          end
          PAUSED: begin
            if (start) r_state <= RUN;
          end
          RUN: begin
            if (tick) begin
              r_tens   <= w_decTens;
              r_units  <= w_decUnits;
              r_borrow <= w_wrap;
              if (w_decZero) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                // Reaching 00 with a non-zero reload value restarts instead of finishing.
                if ((r_reloadTens != 4'd0) || (r_reloadUnits != 4'd0)) begin
                  r_tens      <= r_reloadTens;
                  r_units     <= r_reloadUnits;
                  r_donePulse <= 1'b1;
                  r_state     <= pause ? PAUSED : RUN;
                end else begin
                  r_state <= DONE;
                end
`else
                r_state <= DONE;
`endif
              end else if (pause) begin
                r_state <= PAUSED;
              end
            end else if (pause) begin
              r_state <= PAUSED;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign tens       = r_tens;
  assign units      = r_units;
  assign borrow_out = r_borrow;
  assign running    = (r_state == RUN);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  assign done       = (r_state == DONE) || r_donePulse;
`else
  assign done       = (r_state == DONE);
`endif

endmodule

// File: doc/countdown_mod60.md
Name: countdown_mod60

Overview:
- Two-digit countdown timer built from a units digit (mod UNITS_MOD) and a tens digit (mod TENS_MOD). Defaults give a 59..00 seconds down-counter.
- This is the down-counting counterpart of the team's mod-6 up-counter. It is the tens/units stage of the timer datapath.
- It has parallel load, start/pause control, a tick enable, zero detection, and a borrow-out pulse for cascading into a minutes stage.
- Fully synchronous to clk except the asynchronous reset.

Parameters:
- UNITS_MOD, 10, modulus of the units digit (2..16).
- TENS_MOD, 6, modulus of the tens digit (2..16).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  parallel-load strobe.
- load_tens  input  4  tens value to load.
- load_units  input  4  units value to load.
- start  input  1  start/resume request.
- pause  input  1  pause request.
- tick  input  1  count-enable pulse; one decrement per high cycle.
- tens  output  4  current tens digit.
- units  output  4  current units digit.
- running  output  1  high while in state RUN.
- done  output  1  high while in state DONE.
- borrow_out  output  1  one-cycle pulse on a units wrap 0 -> UNITS_MOD-1.

Behaviour:
- Reset (rst=1, asynchronous): state IDLE, tens=0, units=0, running=0, done=0, borrow_out=0. The reset dominates all inputs. A reset asserted mid-count aborts immediately.
- States: IDLE, RUN, PAUSED, DONE. All transitions happen on the rising edge of clk.
- Load:
  - Accepted in IDLE, PAUSED and DONE; ignored in RUN.
  - Values are clamped: load_units >= UNITS_MOD gives UNITS_MOD-1, and load_tens >= TENS_MOD gives TENS_MOD-1.
  - Load in DONE or PAUSED moves to IDLE. Load in IDLE stays in IDLE.
- Priority in IDLE/PAUSED: load > start. If both are asserted, the load happens and start is ignored.
- IDLE:
  - start with count != 00 -> RUN.
  - start with count == 00 -> DONE.
- RUN, on a cycle with tick=1:
  - units>0: units-1.
  - units==0 and tens>0: units=UNITS_MOD-1, tens-1, borrow_out=1 for that cycle.
  - If the new value is 00 -> DONE on the same edge; done=1 from the next cycle.
- RUN without tick: the count holds.
- RUN with pause=1 -> PAUSED. If tick is also 1 in that cycle, the decrement is applied first, then the block pauses. If the decrement reaches 00, DONE wins over PAUSED.
- PAUSED:
  - The count holds and tick is ignored.
  - start -> RUN.
  - pause is a no-op.
- DONE:
  - The count stays at 00 and tick is ignored.
  - start is ignored.
  - Only load or rst leaves DONE.
- Outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.
- borrow_out is a registered one-cycle pulse. It is never asserted outside RUN.
- Latency: a tick sampled at edge N is visible on tens/units after edge N.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- With the macro defined:
  - The last accepted (clamped) load value is kept in a reload register; its reset value is 00.
  - When RUN reaches 00, the block reloads that value on the same edge and stays in RUN.
  - done pulses high for exactly one cycle.
  - If the reload value is 00, the block goes to DONE as in normal operation.
- Without the macro: no reload register, and the behaviour is exactly as described above.

Test Plan:
- rst pulsed mid-cycle while the count is 3/7 in RUN -> immediately tens=0, units=0, running=0, done=0, with no wait for a clk edge.
- load 2/1, start, then 21 ticks -> 21, 20, 19 (borrow_out=1 on that edge only), ..., 00. done=1 and running=0 after the 21st tick.
- load 9/12 with defaults -> tens=5, units=9 (clamped). A further 59 ticks reach 00.
- In RUN at 0/4: pause and tick in the same cycle -> 0/3 and state PAUSED. Ticks are ignored; start resumes.
- load and start together in IDLE with 1/0 -> loads 1/0, stays IDLE, running=0. Start with 00 loaded -> DONE.
- With COUNTDOWN_AUTO_RELOAD_EN: load 0/3, start, 3 ticks -> 02, 01, then reload to 03. done is high for 1 cycle and running stays 1.
